gray_sync_decoder: RTL and testbench
====================================

// Module: gray_sync_decoder
// PURPOSE
//  Receiving side of the binary-to-gray stage: takes a gray-coded count/pointer produced in
//  another clock domain, synchronises it into clk, decodes it back to binary and reports
//  per-cycle change, increment delta and (optionally) illegal multi-bit gray transitions.
//  Sits between the remote bin->gray encoder and local consumers (FIFO full/empty logic, rate counters).
// PARAMETERS
//  WIDTH        4   width of gray_in / bin_out / delta (>=2)
//  SYNC_STAGES  2   flip-flops in the synchroniser chain (>=2)
// PORTS
//  clk      input   1      destination-domain clock
//  rst_n    input   1      asynchronous, active-low reset
//  gray_in  input   WIDTH  gray-coded value from remote domain (asynchronous to clk)
//  err_clr  input   1      synchronous clear of sticky err
//  bin_out  output  WIDTH  decoded binary of the synchronised gray value
//  delta    output  WIDTH  (new_bin - prev_bin) mod 2^WIDTH, valid while changed=1
//  changed  output  1      one-cycle pulse: synchronised gray value differs from previous sample
//  err      output  1      sticky: >1 gray bit changed between consecutive synchronised samples
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, release on clk edge): all sync flops, gray_q, bin_out,
//    delta, changed, err = 0. Upstream encoder also resets to 0, so first sample is consistent.
//  - Sync chain: sync[0] <= gray_in; sync[k] <= sync[k-1]; gray_s = sync[SYNC_STAGES-1].
//  - Decode g2b: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0 (pure XOR, no carry).
//  - Output register stage, every clk, using old gray_q:
//      gray_q  <= gray_s
//      bin_out <= g2b(gray_s)
//      changed <= (gray_s != gray_q)
//      delta   <= (gray_s != gray_q) ? g2b(gray_s) - g2b(gray_q) (mod 2^WIDTH) : 0
//  - Latency: gray_in change to bin_out/changed update = SYNC_STAGES+1 clk edges (3 by default).
//  - Wrap-around: gray 1000 (bin 15) -> 0000 (bin 0) gives delta=1, no err.
//  - Held input: changed=0, delta=0, bin_out stable; no further pulses.
//  - Backward step (e.g. bin 5->4) is legal single-bit gray change: delta = all-ones (-1 mod 2^W).
//  - err: set when popcount(gray_s ^ gray_q) > 1; stays 1 until err_clr=1 at a clk edge.
//    Set and err_clr in same cycle: set wins (err stays 1).
//  - Reset mid-operation: all state cleared immediately; after release, pipeline refills and the
//    first non-zero synchronised value is compared against 0 (may legitimately flag err).
// CONFIGURATION
//  GRAY_SYNC_ERR_EN defined: popcount comparator and sticky err flop built as above.
//  GRAY_SYNC_ERR_EN undefined: no comparator/flop; err tied 0; err_clr ignored. Ports unchanged.
// STRUCTURE
//  - Shared package gray_pkg: function gray2bin(), function bin2gray() (shared with the encoder),
//    function popcount(); localparam GRAY_RST_VAL = '0.
//  - One sub-module: gray_to_bin (combinational, parameter WIDTH), instanced twice (gray_s, gray_q)
//    or once with gray_q's binary kept in a register; choice is implementer's.
// TESTING
//  1 Reset: rst_n=0 with gray_in=0110 -> bin_out=0, changed=0, delta=0, err=0 throughout reset.
//  2 Full sweep: drive bin2gray(0..15) one value per 4 clk -> bin_out tracks 0..15 exactly 3
//    edges after each change, changed pulses 1 cycle, delta=1 each step, err=0.
//  3 Wrap: gray 1000 -> 0000 -> bin_out 15 -> 0, delta=0001, changed=1, err=0.
//  4 Illegal jump: gray 0000 -> 0011 -> err=1 (ERR_EN build), delta=0010; err holds after input
//    stabilises; err_clr pulse -> err=0 next edge; err_clr coincident with new bad jump -> err=1.
//  5 Async reset mid-sweep at bin 9 -> all outputs 0 at once; on release with gray_in=1101
//    pipeline refills, bin_out=9 after 3 edges.
//  6 Build without GRAY_SYNC_ERR_EN: repeat scenario 4 -> err constant 0, other outputs identical.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared gray-code helpers, used by the local decoder and by the remote
// bin->gray encoder. The functions work on a GRAY_MAX_W-bit container.
// Narrower callers zero-extend their operands, so the prefix XOR is not disturbed.
package gray_pkg;

   localparam int unsigned GRAY_MAX_W = 32;

   // Both ends of the crossing reset to this value, so the first sample
   // after reset is consistent.
   localparam logic [GRAY_MAX_W-1:0] GRAY_RST_VAL = '0;

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         if (v[i]) cnt++;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray -> binary decode at the exact port width.
// It uses the same prefix-XOR as gray_pkg::gray2bin: the MSB is copied,
// and each lower bit is the XOR of the bit above it with its own gray bit.
module gray_to_bin #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   // MSB-first prefix XOR; no carry chain involved.
   always_comb begin
      bin_o            = '0;
      bin_o[WIDTH-1]   = gray_i[WIDTH-1];
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
         bin_o[i] = bin_o[i+1] ^ gray_i[i];
      end
   end

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive side of a gray-coded clock-domain crossing. The decoder
// synchronises gray_in into clk and decodes it to binary. Each cycle it
// reports change, increment delta and multi-bit gray jumps.
// Optional feature macro: GRAY_SYNC_ERR_EN
//   defined   -> popcount comparator plus sticky err flop; err_clr clears it.
//   undefined -> err is tied low and err_clr is ignored. The ports stay the same.
module gray_sync_decoder
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] delta,
   output logic             changed,
   output logic             err
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] gray_s;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_s, bin_prev;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] delta_q, delta_d;
   logic             changed_q, changed_d;
   logic             gray_diff;

   // Multi-flop synchroniser. Only one bit moves per legal step, so a
   // metastable capture resolves to either the old code or the new code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(SYNC_STAGES); k++) begin
            sync_q[k] <= GRAY_RST_VAL[WIDTH-1:0];
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int k = 1; k < int'(SYNC_STAGES); k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign gray_s = sync_q[SYNC_STAGES-1];

   // The previous sample is decoded again from gray_q rather than read from
   // bin_q. This keeps the delta path independent of the output register.
   gray_to_bin #(.WIDTH(WIDTH)) u_g2b_new (
      .gray_i (gray_s),
      .bin_o  (bin_s)
   );

   gray_to_bin #(.WIDTH(WIDTH)) u_g2b_prev (
      .gray_i (gray_q),
      .bin_o  (bin_prev)
   );

   assign gray_diff = (gray_s != gray_q);

   // Next-state for the output stage. Subtraction wraps modulo 2^WIDTH,
   // so 15->0 gives +1 and a backward step gives all-ones.
   always_comb begin
      gray_d    = gray_s;
      bin_d     = bin_s;
      changed_d = gray_diff;
      delta_d   = '0;
      if (gray_diff) begin
         delta_d = bin_s - bin_prev;
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q    <= GRAY_RST_VAL[WIDTH-1:0];
         bin_q     <= '0;
         delta_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         gray_q    <= gray_d;
         bin_q     <= bin_d;
         delta_q   <= delta_d;
         changed_q <= changed_d;
      end
   end

   assign bin_out = bin_q;
   assign delta   = delta_q;
   assign changed = changed_q;

`ifdef GRAY_SYNC_ERR_EN
   logic err_q, err_d;
   logic multi_flip;

   assign multi_flip = (popcount(GRAY_MAX_W'(gray_s ^ gray_q)) > 32'd1);

   // Sticky error flag. A new illegal jump takes priority over a
   // clear that arrives in the same cycle.
   always_comb begin
      err_d = err_q;
      if (err_clr)    err_d = 1'b0;
      if (multi_flip) err_d = 1'b1;
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
// The expected err value follows the GRAY_SYNC_ERR_EN build option.
module tb_gray_sync_decoder;

`ifdef GRAY_SYNC_ERR_EN
   localparam logic E = 1'b1;
`else
   localparam logic E = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] gray_in;
   logic       err_clr;
   logic [3:0] bin_out;
   logic [3:0] delta;
   logic       changed;
   logic       err;

   int n_vec;
   int n_err;

   typedef struct {
      logic [3:0] g;
      logic       clr;
      logic [3:0] bin;
      logic [3:0] dl;
      logic       ch;
      logic       er;
   } vec_t;

   vec_t tbl [15];

   gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .gray_in (gray_in),
      .err_clr (err_clr),
      .bin_out (bin_out),
      .delta   (delta),
      .changed (changed),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] b, input logic [3:0] d,
                             input logic ch, input logic er);
      chk({tag, ".bin_out"}, bin_out, b);
      chk({tag, ".delta"},   delta,   d);
      chk({tag, ".changed"}, {3'b000, changed}, {3'b000, ch});
      chk({tag, ".err"},     {3'b000, err},     {3'b000, er});
   endtask

   // Move to binary value nb from pb and hold it for 4 clocks. The new
   // value must show on the 3rd edge.
   task automatic seg(input string tag, input logic [3:0] nb, input logic [3:0] pb,
                      input logic [3:0] d);
      gray_in = b2g(nb);
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c < 3)       expect_out(tag, pb, 4'd0, 1'b0, 1'b0);
         else if (c == 3) expect_out(tag, nb, d,    1'b1, 1'b0);
         else             expect_out(tag, nb, 4'd0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      gray_in = 4'b0110;
      err_clr = 1'b0;

      //                g        clr   bin    delta  ch    err
      tbl[0]  = '{4'b0011, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0};
      tbl[1]  = '{4'b0011, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0};
      tbl[2]  = '{4'b0011, 1'b0, 4'd2, 4'd2,  1'b1, E   };
      tbl[3]  = '{4'b0011, 1'b0, 4'd2, 4'd0,  1'b0, E   };
      tbl[4]  = '{4'b0011, 1'b1, 4'd2, 4'd0,  1'b0, 1'b0};
      tbl[5]  = '{4'b0011, 1'b0, 4'd2, 4'd0,  1'b0, 1'b0};
      tbl[6]  = '{4'b0101, 1'b0, 4'd2, 4'd0,  1'b0, 1'b0};
      tbl[7]  = '{4'b0101, 1'b0, 4'd2, 4'd0,  1'b0, 1'b0};
      tbl[8]  = '{4'b0101, 1'b1, 4'd6, 4'd4,  1'b1, E   };
      tbl[9]  = '{4'b0101, 1'b0, 4'd6, 4'd0,  1'b0, E   };
      tbl[10] = '{4'b0101, 1'b1, 4'd6, 4'd0,  1'b0, 1'b0};
      tbl[11] = '{4'b0111, 1'b0, 4'd6, 4'd0,  1'b0, 1'b0};
      tbl[12] = '{4'b0111, 1'b0, 4'd6, 4'd0,  1'b0, 1'b0};
      tbl[13] = '{4'b0111, 1'b0, 4'd5, 4'hF,  1'b1, 1'b0};
      tbl[14] = '{4'b0111, 1'b0, 4'd5, 4'd0,  1'b0, 1'b0};

      // Reset is held with a non-zero input present.
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("reset", 4'd0, 4'd0, 1'b0, 1'b0);
      end
      gray_in = 4'b0000;
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      expect_out("post_reset", 4'd0, 4'd0, 1'b0, 1'b0);

      // Full forward sweep 1..15.
      for (int v = 1; v < 16; v++) begin
         seg("sweep", 4'(v), 4'(v - 1), 4'd1);
      end

      // Wrap 15 -> 0.
      seg("wrap", 4'd0, 4'd15, 4'd1);

      // Illegal jumps, clear, clear-vs-set priority, backward step.
      for (int r = 0; r < 15; r++) begin
         gray_in = tbl[r].g;
         err_clr = tbl[r].clr;
         step();
         expect_out($sformatf("tbl%0d", r), tbl[r].bin, tbl[r].dl, tbl[r].ch, tbl[r].er);
      end
      err_clr = 1'b0;

      // Walk up to bin 9, then apply an asynchronous reset between edges.
      seg("pre_rst", 4'd6, 4'd5, 4'd1);
      seg("pre_rst", 4'd7, 4'd6, 4'd1);
      seg("pre_rst", 4'd8, 4'd7, 4'd1);
      seg("pre_rst", 4'd9, 4'd8, 4'd1);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      step();
      expect_out("rst_hold", 4'd0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      expect_out("refill1", 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      expect_out("refill2", 4'd0, 4'd0, 1'b0, 1'b0);
      step();
      expect_out("refill3", 4'd9, 4'd9, 1'b1, E);
      step();
      expect_out("refill4", 4'd9, 4'd0, 1'b0, E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
